// File: rtl/fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// fifo_sync_flags
//
// Single-clock FIFO for the grayscale pixel pipeline. It reports its occupancy
// count, programmable almost-full/almost-empty flags and sticky
// overflow/underflow flags, and it has a synchronous flush. The producer and
// the consumer are both clocked by wr_clk.
//
// Optional feature macro: FIFO_FWFT_EN
//   defined   : first-word-fall-through. o_dout shows the head word whenever
//               the FIFO is not empty. o_dout_valid = !empty. An accepted read
//               consumes the word that is on o_dout.
//   undefined : standard mode. An accepted read registers the head word onto
//               o_dout and pulses o_dout_valid for one cycle (latency 1).
//
// Parameters
//   DATA_WIDTH     word width in bits
//   DEPTH          number of words (power of two, >= 2)
//   AFULL_THRESH   o_almost_full  when count >= AFULL_THRESH
//   AEMPTY_THRESH  o_almost_empty when count <= AEMPTY_THRESH
//
// Ports
//   wr_clk          clock for all logic
//   reset           asynchronous, active-high reset
//   i_flush         synchronous clear of contents/pointers (sticky flags kept)
//   i_wr_en, i_din  write request and data
//   i_rd_en         read request
//   o_dout          read data
//   o_dout_valid    o_dout carries a freshly read word
//   o_full/o_empty  count == DEPTH / count == 0
//   o_almost_full   count >= AFULL_THRESH
//   o_almost_empty  count <= AEMPTY_THRESH
//   o_count         words stored, 0..DEPTH
//   o_overflow      sticky: write attempted while full
//   o_underflow     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_flags #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                      wr_clk,
    input  logic                      reset,
    input  logic                      i_flush,
    input  logic                      i_wr_en,
    input  logic [DATA_WIDTH-1:0]     i_din,
    input  logic                      i_rd_en,
    output logic [DATA_WIDTH-1:0]     o_dout,
    output logic                      o_dout_valid,
    output logic                      o_full,
    output logic                      o_empty,
    output logic                      o_almost_full,
    output logic                      o_almost_empty,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_overflow,
    output logic                      o_underflow
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_T     = (AW+1)'(AFULL_THRESH);
    localparam logic [AW:0]   AE_T     = (AW+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Pointers carry one extra MSB so they wrap naturally past DEPTH-1.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_count;
    logic [AW:0] w_count_next;

    logic r_full;
    logic r_empty;
    logic r_almost_full;
    logic r_almost_empty;
    logic r_overflow;
    logic r_underflow;

    logic w_wr_acc;
    logic w_rd_acc;

    // The registered full/empty flags are the pre-edge state, so they gate
    // acceptance. A flush overrides both requests.
    assign w_wr_acc = i_wr_en & ~r_full  & ~i_flush;
    assign w_rd_acc = i_rd_en & ~r_empty & ~i_flush;

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + CNT_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    // Storage is not reset, which keeps it mappable to RAM. A write is blocked
    // while reset is asserted.
    always_ff @(posedge wr_clk) begin
        if (w_wr_acc && !reset) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    // Pointers, count and all flags. The flags are registered from the next
    // count, so they are valid the cycle after the edge that caused them.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + CNT_ONE;
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + CNT_ONE;
                // The sticky error flags are set only by real attempts.
                // A flush cycle ignores the requests, so it cannot set them.
                if (i_wr_en && r_full)  r_overflow  <= 1'b1;
                if (i_rd_en && r_empty) r_underflow <= 1'b1;
            end
            r_count        <= w_count_next;
            r_full         <= (w_count_next == CNT_FULL);
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= AF_T);
            r_almost_empty <= (w_count_next <= AE_T);
        end
    end

`ifdef FIFO_FWFT_EN
    // The head word is always presented. Its value is meaningless while the
    // FIFO is empty, but it stays stable because memory only changes on writes.
    assign o_dout       = r_mem[r_rd_ptr[AW-1:0]];
    assign o_dout_valid = ~r_empty;
`else
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;

    // Registered read port. o_dout holds its value between accepted reads.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
`endif

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Testbench for fifo_sync_flags (DEPTH=8, DATA_WIDTH=8, AFULL=6, AEMPTY=2).
// The reference model is a queue of words plus sticky flags. The expected
// flags are derived from the queue size.
module tb_fifo_sync_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          wr_clk = 1'b0;
    logic          reset  = 1'b1;
    logic          i_flush = 1'b0;
    logic          i_wr_en = 1'b0;
    logic [DW-1:0] i_din   = '0;
    logic          i_rd_en = 1'b0;
    logic [DW-1:0] o_dout;
    logic          o_dout_valid;
    logic          o_full;
    logic          o_empty;
    logic          o_almost_full;
    logic          o_almost_empty;
    logic [3:0]    o_count;
    logic          o_overflow;
    logic          o_underflow;

    fifo_sync_flags #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .wr_clk        (wr_clk),
        .reset         (reset),
        .i_flush       (i_flush),
        .i_wr_en       (i_wr_en),
        .i_din         (i_din),
        .i_rd_en       (i_rd_en),
        .o_dout        (o_dout),
        .o_dout_valid  (o_dout_valid),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_almost_full (o_almost_full),
        .o_almost_empty(o_almost_empty),
        .o_count       (o_count),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow)
    );

    always #5 wr_clk = ~wr_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [DW-1:0] model_q[$];
    logic          exp_ovf  = 1'b0;
    logic          exp_unf  = 1'b0;
    logic [DW-1:0] exp_dout = '0;
    logic          exp_dv   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int cnt;
        cnt = model_q.size();
        check_eq({tag, ":count"},  32'(o_count),        32'(cnt));
        check_eq({tag, ":full"},   32'(o_full),         32'(cnt == DEPTH));
        check_eq({tag, ":empty"},  32'(o_empty),        32'(cnt == 0));
        check_eq({tag, ":afull"},  32'(o_almost_full),  32'(cnt >= AF));
        check_eq({tag, ":aempty"}, 32'(o_almost_empty), 32'(cnt <= AE));
        check_eq({tag, ":ovf"},    32'(o_overflow),     32'(exp_ovf));
        check_eq({tag, ":unf"},    32'(o_underflow),    32'(exp_unf));
`ifdef FIFO_FWFT_EN
        check_eq({tag, ":dv"}, 32'(o_dout_valid), 32'(cnt > 0));
        if (cnt > 0) check_eq({tag, ":dout"}, 32'(o_dout), 32'(model_q[0]));
`else
        check_eq({tag, ":dv"},   32'(o_dout_valid), 32'(exp_dv));
        check_eq({tag, ":dout"}, 32'(o_dout),       32'(exp_dout));
`endif
    endtask

    // One clock cycle. It is called at a negedge and returns at the next
    // negedge, after the outputs have been checked.
    task automatic step(input string tag, input logic f, input logic w,
                        input logic r, input logic [DW-1:0] d);
        bit wr_ok;
        bit rd_ok;
        i_flush = f;
        i_wr_en = w;
        i_rd_en = r;
        i_din   = d;
        if (f) begin
            model_q.delete();
            exp_dv = 1'b0;
        end else begin
            wr_ok = w && (model_q.size() < DEPTH);
            rd_ok = r && (model_q.size() > 0);
            if (w && !wr_ok) exp_ovf = 1'b1;
            if (r && !rd_ok) exp_unf = 1'b1;
            exp_dv = rd_ok;
            if (rd_ok) exp_dout = model_q.pop_front();
            if (wr_ok) model_q.push_back(d);
        end
        @(posedge wr_clk);
        @(negedge wr_clk);
        $display("[TB] %s flush=%0b wr=%0b rd=%0b din=%02h -> count=%0d dout=%02h dv=%0b",
                 tag, f, w, r, d, o_count, o_dout, o_dout_valid);
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        exp_dout = '0;
        exp_dv   = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v;
        repeat (3) @(negedge wr_clk);
        reset = 1'b0;
        model_reset();
        check_all("reset");

        // Fill the FIFO to full
        for (int i = 1; i <= 8; i++) begin
            v = DW'(i * 8'h11);
            step("fill", 1'b0, 1'b1, 1'b0, v);
        end
        // Write while full, then drain the FIFO in order
        step("ovf", 1'b0, 1'b1, 1'b0, 8'h99);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
        // Read while empty, then write and read together while empty
        step("unf", 1'b0, 1'b0, 1'b1, 8'h00);
        step("unf_wr", 1'b0, 1'b1, 1'b1, 8'hA5);
        step("rd_a5", 1'b0, 1'b0, 1'b1, 8'h00);

        // Pointer wrap with a simultaneous read/write at count 4
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 4; i++) step("wrap_w", 1'b0, 1'b1, 1'b0, DW'($urandom));
            step("wrap_rw", 1'b0, 1'b1, 1'b1, DW'($urandom));
            step("wrap_rw", 1'b0, 1'b1, 1'b1, DW'($urandom));
            for (int i = 0; i < 4; i++) step("wrap_r", 1'b0, 1'b0, 1'b1, 8'h00);
        end

        // Flush at count 5 together with wr_en
        for (int i = 0; i < 5; i++) step("pre_flush", 1'b0, 1'b1, 1'b0, DW'($urandom));
        step("flush", 1'b1, 1'b1, 1'b0, 8'h77);

        // Assert reset asynchronously in the middle of a burst
        for (int i = 0; i < 3; i++) step("burst", 1'b0, 1'b1, 1'b0, DW'($urandom));
        i_wr_en = 1'b1;
        i_din   = 8'h5A;
        #2 reset = 1'b1;
        #1;
        $display("[TB] async reset mid-burst -> count=%0d empty=%0b ovf=%0b",
                 o_count, o_empty, o_overflow);
        check_eq("areset:count",  32'(o_count),        32'd0);
        check_eq("areset:empty",  32'(o_empty),        32'd1);
        check_eq("areset:aempty", 32'(o_almost_empty), 32'd1);
        check_eq("areset:full",   32'(o_full),         32'd0);
        check_eq("areset:afull",  32'(o_almost_full),  32'd0);
        check_eq("areset:ovf",    32'(o_overflow),     32'd0);
        check_eq("areset:unf",    32'(o_underflow),    32'd0);
        check_eq("areset:dv",     32'(o_dout_valid),   32'd0);
`ifndef FIFO_FWFT_EN
        check_eq("areset:dout",   32'(o_dout),         32'd0);
`endif
        @(negedge wr_clk);
        i_wr_en = 1'b0;
        reset   = 1'b0;
        model_reset();
        check_all("post_reset");

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(63) == 0),
                 ($urandom_range(99) < 55),
                 ($urandom_range(99) < 50),
                 DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
